// File: rtl/cv32e40p_pkg.sv
// Shared constants and types for the fast-interrupt scheduler: core irq bit
// positions for the standard lines and the presentation FSM states.
package cv32e40p_pkg;

  localparam int FAST_IRQ_BASE = 16;
  localparam int CSR_MSIX_BIT  = 3;
  localparam int CSR_MTIX_BIT  = 7;
  localparam int CSR_MEIX_BIT  = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } fast_irq_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_fast_irq_sched_if.sv
// Core-side link of the scheduler: the irq vector toward the core and the
// core's interrupt-taken pulse with the id of the taken interrupt.
interface cv32e40p_fast_irq_sched_if;

  // Handshake: irq_o is a level held by the scheduler; the core answers with a
  // single-cycle irq_ack_i pulse, and irq_id_i is only meaningful while
  // irq_ack_i is high. There is no backpressure on either side.
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;

  modport master (
    output irq_o,
    input  irq_ack_i,
    input  irq_id_i
  );

  modport slave (
    input  irq_o,
    output irq_ack_i,
    output irq_id_i
  );

endinterface

// File: rtl/cv32e40p_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo
// NUM_SRC. Purely combinational.
module cv32e40p_rr_pick #(
  parameter int NUM_SRC = 16,
  parameter int IDX_W   = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
        sum = sum - (IDX_W + 1)'(NUM_SRC);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_fast_irq_sched.sv
// Fast-interrupt scheduler: latches peripheral sources into pending state and
// presents one fast irq (ids 16..31) at a time to the core, round-robin.
module cv32e40p_fast_irq_sched
  import cv32e40p_pkg::*;
#(
  parameter  int NUM_SRC = 16,
  localparam int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_i,
  input  logic [NUM_SRC-1:0]        edge_mode_i,
  input  logic [NUM_SRC-1:0]        src_en_i,
  input  logic [NUM_SRC-1:0]        sw_set_i,
  input  logic [NUM_SRC-1:0]        sw_clr_i,
  input  logic                      msip_i,
  input  logic                      mtip_i,
  input  logic                      meip_i,
  cv32e40p_fast_irq_sched_if.master core_if,
  output logic [NUM_SRC-1:0]        pending_o,
  output logic                      busy_o,
  output fast_irq_state_e           state_o,
  output logic [IDX_W-1:0]          rr_ptr_o
);

  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] rise, eligible, ack_clr;
  fast_irq_state_e    state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   sel_inc;
  logic [2:0]         std_q, std_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [4:0]         sel_id;
  logic               ack_hit;
  logic [31:0]        irq;

  assign src_d    = src_i;
  assign std_d    = {meip_i, mtip_i, msip_i};
  assign rise     = src_i & ~src_q;
  assign eligible = pend_q & src_en_i;
  assign sel_id   = 5'(FAST_IRQ_BASE) + 5'(sel_q);
  assign ack_hit  = (state_q == PRESENT) && core_if.irq_ack_i && (core_if.irq_id_i == sel_id);
  assign sel_inc  = (sel_q == IDX_W'(NUM_SRC - 1)) ? '0 : sel_q + IDX_W'(1);

  cv32e40p_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Edge sources: any set this cycle beats any clear. Level sources mirror src_i.
  always_comb begin
    ack_clr = '0;
    if (ack_hit) begin
      ack_clr[sel_q] = 1'b1;
    end
    pend_d = (edge_mode_i & (rise | sw_set_i | (pend_q & ~(sw_clr_i | ack_clr))))
           | (~edge_mode_i & src_i);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_hit) begin
          rr_ptr_d = sel_inc;
          state_d  = GAP;
        end else if (!eligible[sel_q]) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq               = '0;
    irq[CSR_MSIX_BIT] = std_q[0];
    irq[CSR_MTIX_BIT] = std_q[1];
    irq[CSR_MEIX_BIT] = std_q[2];
    if (state_q == PRESENT) begin
      irq[sel_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      pend_q   <= '0;
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      std_q    <= '0;
    end else begin
      src_q    <= src_d;
      pend_q   <= pend_d;
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      std_q    <= std_d;
    end
  end

  assign core_if.irq_o = irq;
  assign pending_o     = pend_q;
  assign busy_o        = (state_q == PRESENT);
  assign state_o       = state_q;
  assign rr_ptr_o      = rr_ptr_q;

endmodule
